// File: rtl/q_frag_pipe.sv
// q_frag_pipe: WIDTH-channel, DEPTH-stage Q_FRAG register chain with sync reset/set, stall enable and fill flag.
module q_frag_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter     MODE  = "INT"
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             QST,
  input  logic             QEN,
  input  logic [WIDTH-1:0] CZI,
  input  logic [WIDTH-1:0] QDI,
  input  logic [WIDTH-1:0] QDS,
  output logic [WIDTH-1:0] QZ,
  output logic             QZV
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [WIDTH-1:0] stage [DEPTH];
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] d;
  generate
    if (MODE == "INT")      assign sel = '0;
    else if (MODE == "EXT") assign sel = '1;
    else if (MODE == "DYN") assign sel = QDS;
    else                    $error("q_frag_pipe: MODE must be INT, EXT or DYN");
  endgenerate
  // a single per-bit mux keeps all inputs live; the static modes fold sel to a constant
  assign d = (sel & QDI) | (~sel & CZI);
  always_ff @(posedge QCK) begin
    if (QRT) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      fill <= '0;
    end else if (QST) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '1;
      fill <= FULL;
    end else if (QEN) begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      fill <= (fill == FULL) ? fill : fill + 1'b1;
    end
  end
  assign QZ  = stage[DEPTH-1];
  assign QZV = (fill == FULL);
endmodule
